// File: rtl/uart_tx_frame_pkg.sv
// Shared UART framing definitions: parity-mode codes, FSM state encoding
// and the parity helper. The matching receiver imports this package too.
package uart_tx_frame_pkg;

  // Parity-mode codes carried by the P_UART_CHECK parameter
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Frame FSM state encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  // Parity bit for up to 8 data bits. Callers zero-extend narrower words;
  // the extra zeros do not change the reduction XOR.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic result;
    case (mode)
      PAR_ODD:  result = ~(^data);
      PAR_EVEN: result = ^data;
      default:  result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// UART transmit framer. Clocked at the bit rate: each i_clk cycle is one bit
// on the line. Frame = start, data LSB first, optional parity, stop bit(s).
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
  input  logic                         i_user_tx_valid,
  output logic                         o_user_tx_ready,
  output logic                         o_uart_tx
);

  // Unsupported parameter values fall back to no parity / one stop bit
  localparam int CHECK_MODE = ((P_UART_CHECK == PAR_ODD) || (P_UART_CHECK == PAR_EVEN))
                              ? P_UART_CHECK : PAR_NONE;
  localparam int STOP_BITS  = (P_UART_STOP_WIDTH == 2) ? 2 : 1;

  // Counter indexes data bits (0..W-1) and stop bits (0..STOP_BITS-1)
  localparam int CNT_W = (P_UART_DATA_WIDTH > 2) ? $clog2(P_UART_DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(P_UART_DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

  uart_state_e                  state_r;
  uart_state_e                  state_s;
  logic [CNT_W-1:0]             cnt_r;
  logic [CNT_W-1:0]             cnt_s;
  logic [CNT_W-1:0]             next_idx_s;
  logic [P_UART_DATA_WIDTH-1:0] data_r;
  logic [P_UART_DATA_WIDTH-1:0] data_s;
  logic [P_UART_DATA_WIDTH-1:0] data_shift_s;
  logic                         parity_s;
  logic                         tx_r;
  logic                         tx_s;
  logic                         ready_r;
  logic                         ready_s;

  // Parity and next data bit always come from the captured word, never the live input
  assign next_idx_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign data_shift_s = data_r >> next_idx_s;
  assign parity_s     = parity_bit(8'(data_r), CHECK_MODE);

  // Next-state logic; line level and ready are computed one cycle ahead so both leave registers
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    data_s  = data_r;
    tx_s    = tx_r;
    ready_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s = '0;
        if (i_user_tx_valid && ready_r) begin
          state_s = ST_START;
          data_s  = i_user_tx_data;
          tx_s    = 1'b0;
          ready_s = 1'b0;
        end else begin
          tx_s    = 1'b1;
          ready_s = 1'b1;
        end
      end
      ST_START: begin
        state_s = ST_DATA;
        cnt_s   = '0;
        tx_s    = data_r[0];
      end
      ST_DATA: begin
        if (cnt_r == DATA_LAST) begin
          cnt_s = '0;
          if (CHECK_MODE != PAR_NONE) begin
            state_s = ST_CHECK;
            tx_s    = parity_s;
          end else begin
            state_s = ST_STOP;
            tx_s    = 1'b1;
          end
        end else begin
          cnt_s = next_idx_s;
          tx_s  = data_shift_s[0];
        end
      end
      ST_CHECK: begin
        state_s = ST_STOP;
        cnt_s   = '0;
        tx_s    = 1'b1;
      end
      ST_STOP: begin
        tx_s = 1'b1;
        if (cnt_r == STOP_LAST) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
          ready_s = 1'b1;
        end else begin
          cnt_s = next_idx_s;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        tx_s    = 1'b1;
        ready_s = 1'b1;
      end
    endcase
  end

  // State, counter, captured data and output registers; reset forces an idle-high line
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      data_r  <= '0;
      tx_r    <= 1'b1;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      data_r  <= data_s;
      tx_r    <= tx_s;
      ready_r <= ready_s;
    end
  end

  assign o_uart_tx       = tx_r;
  assign o_user_tx_ready = ready_r;

endmodule
